// File: rtl/signed_div_sequencer.sv
// Request/response sequencer around a combinational signed divider.
// Holds operands for a settle window, traps zero divisors, queues results.
module signed_div_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       In_Valid,
    output logic       In_Ready,
    input  logic [3:0] In_Dividend,
    input  logic [3:0] In_Divisor,
    input  logic [1:0] In_Mode,
    output logic [3:0] Div_Dividend,
    output logic [3:0] Div_Divisor,
    output logic       Div_S0,
    output logic       Div_S1,
    input  logic [5:0] Div_Quotient,
    input  logic [3:0] Div_Remainder,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [5:0] Out_Quotient,
    output logic [3:0] Out_Remainder,
    output logic       Out_DivZero,
    output logic       Busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        ZERO  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    dvd_q, dvd_d;
    logic [3:0]    dvs_q, dvs_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    zdvd_q, zdvd_d;

    logic [5:0]    fq_q [FIFO_DEPTH];
    logic [5:0]    fq_d [FIFO_DEPTH];
    logic [3:0]    fr_q [FIFO_DEPTH];
    logic [3:0]    fr_d [FIFO_DEPTH];
    logic          fz_q [FIFO_DEPTH];
    logic          fz_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          not_empty;
    logic          accept;
    logic          pop;
    logic          push;
    logic [5:0]    push_quo;
    logic [3:0]    push_rem;
    logic          push_dz;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign not_empty = (count_q != '0);
    // Gated by reset so the request side looks closed while held in reset.
    assign In_Ready  = Reset && (state_q == IDLE) && !full;
    assign accept    = In_Valid && In_Ready;
    assign pop       = Out_Ready && not_empty;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        mode_d   = mode_q;
        zdvd_d   = zdvd_q;
        push     = 1'b0;
        push_quo = '0;
        push_rem = '0;
        push_dz  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (In_Divisor != 4'd0) begin
                        dvd_d   = In_Dividend;
                        dvs_d   = In_Divisor;
                        mode_d  = In_Mode;
                        cnt_d   = 4'(SETTLE_CYCLES - 1);
                        state_d = DRIVE;
                    end else begin
                        zdvd_d  = In_Dividend;
                        state_d = ZERO;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    push     = 1'b1;
                    push_quo = Div_Quotient;
                    push_rem = Div_Remainder;
                    push_dz  = 1'b0;
                    state_d  = IDLE;
                end
            end
            ZERO: begin
                push     = 1'b1;
                push_quo = '0;
                push_rem = zdvd_q;
                push_dz  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fq_d     = fq_q;
        fr_d     = fr_q;
        fz_d     = fz_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fq_d[wr_ptr_q] = push_quo;
            fr_d[wr_ptr_q] = push_rem;
            fz_d[wr_ptr_q] = push_dz;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            mode_q   <= '0;
            zdvd_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fq_q[i] <= '0;
                fr_q[i] <= '0;
                fz_q[i] <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            mode_q   <= mode_d;
            zdvd_q   <= zdvd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fq_q[i] <= fq_d[i];
                fr_q[i] <= fr_d[i];
                fz_q[i] <= fz_d[i];
            end
        end
    end

    assign Div_Dividend  = dvd_q;
    assign Div_Divisor   = dvs_q;
    assign Div_S0        = mode_q[0];
    assign Div_S1        = mode_q[1];
    assign Busy          = (state_q != IDLE);
    assign Out_Valid     = not_empty;
    assign Out_Quotient  = not_empty ? fq_q[rd_ptr_q] : '0;
    assign Out_Remainder = not_empty ? fr_q[rd_ptr_q] : '0;
    assign Out_DivZero   = not_empty ? fz_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Scoreboard bench for signed_div_sequencer with a settling divider stub.
// Directed handshake, zero, backpressure, reset and mode cases, then random.
module tb_signed_div_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [3:0] In_Dividend = '0;
    logic [3:0] In_Divisor = '0;
    logic [1:0] In_Mode = '0;
    logic [3:0] Div_Dividend;
    logic [3:0] Div_Divisor;
    logic       Div_S0;
    logic       Div_S1;
    logic [5:0] Div_Quotient;
    logic [3:0] Div_Remainder;
    logic       Out_Valid;
    logic       Out_Ready = 1'b0;
    logic [5:0] Out_Quotient;
    logic [3:0] Out_Remainder;
    logic       Out_DivZero;
    logic       Busy;

    typedef struct packed {
        logic [5:0] q;
        logic [3:0] r;
        logic       z;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rdone = 1'b0;

    signed_div_sequencer #(.SETTLE_CYCLES(2), .FIFO_DEPTH(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Dividend(In_Dividend), .In_Divisor(In_Divisor),
        .In_Mode(In_Mode),
        .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor),
        .Div_S0(Div_S0), .Div_S1(Div_S1),
        .Div_Quotient(Div_Quotient), .Div_Remainder(Div_Remainder),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Quotient(Out_Quotient), .Out_Remainder(Out_Remainder),
        .Out_DivZero(Out_DivZero), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Divider stub: answers only once operands have been stable for a cycle.
    function automatic logic [9:0] stub_f(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [1:0] m);
        logic [5:0] q;
        logic [3:0] r;
        if (b == 4'd5) begin
            q = 6'b111110;
            r = 4'd4;
        end else begin
            q = {m, a} ^ {b, 2'b10};
            r = a + b + {2'b00, m};
        end
        return {q, r};
    endfunction

    logic [9:0] bundle, bundle_prev;
    assign bundle = {Div_S1, Div_S0, Div_Dividend, Div_Divisor};
    always @(posedge Clock) bundle_prev <= bundle;
    assign {Div_Quotient, Div_Remainder} = (bundle == bundle_prev) ?
        stub_f(Div_Dividend, Div_Divisor, {Div_S1, Div_S0}) : 10'h2A5;

    function automatic res_t model(input logic [3:0] a,
                                   input logic [3:0] b,
                                   input logic [1:0] m);
        res_t e;
        if (b == 4'd0) begin
            e.q = '0;
            e.r = a;
            e.z = 1'b1;
        end else begin
            {e.q, e.r} = stub_f(a, b, m);
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        res_t held;
        res_t e;
        bit   hold_v;
        hold_v = 1'b0;
        held = '0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    chk("hold_stable",
                        {Out_Quotient, Out_Remainder, Out_DivZero}, held);
                if (In_Ready && Busy)
                    chk("ready_while_busy", 1, 0);
                if (Out_Valid && Out_Ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pop",
                            {Out_Quotient, Out_Remainder, Out_DivZero},
                            32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_data",
                            {Out_Quotient, Out_Remainder, Out_DivZero}, e);
                    end
                end
                hold_v = Out_Valid && !Out_Ready;
                held = {Out_Quotient, Out_Remainder, Out_DivZero};
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] m);
        int n;
        @(posedge Clock);
        #1;
        In_Dividend = a;
        In_Divisor  = b;
        In_Mode     = m;
        In_Valid    = 1'b1;
        n = 0;
        @(negedge Clock);
        while (!In_Ready && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!In_Ready) begin
            chk("accept_timeout", 0, 1);
            In_Valid = 1'b0;
            return;
        end
        @(posedge Clock);
        exp_q.push_back(model(a, b, m));
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic measure(input logic [9:0] drv, output int lat,
                           output int busy);
        lat = 0;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Out_Valid) break;
            lat++;
            if (Busy) begin
                busy++;
                chk("drive_hold", bundle, drv);
            end
        end
    endtask

    task automatic drain();
        @(posedge Clock);
        #1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (!Out_Valid) break;
        end
        @(posedge Clock);
        #1;
        Out_Ready = 1'b0;
    endtask

    initial begin
        int lat;
        int busy;
        logic [3:0] a;
        logic [3:0] b;

        repeat (3) @(posedge Clock);
        #1;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_in_ready", In_Ready, 0);
        chk("rst_div", bundle, 0);
        chk("rst_out_data", {Out_Quotient, Out_Remainder, Out_DivZero}, 0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("idle_in_ready", In_Ready, 1);

        send(4'b1110, 4'b0101, 2'b01);
        measure({2'b01, 4'b1110, 4'b0101}, lat, busy);
        chk("basic_latency", lat, 2);
        chk("basic_drive_cycles", busy, 2);
        chk("basic_q", Out_Quotient, 6'b111110);
        chk("basic_r", Out_Remainder, 4'd4);
        chk("basic_dz", Out_DivZero, 0);
        drain();

        send(4'b1101, 4'b0000, 2'b11);
        measure({2'b01, 4'b1110, 4'b0101}, lat, busy);
        chk("zero_latency", lat, 1);
        chk("zero_q", Out_Quotient, 0);
        chk("zero_r", Out_Remainder, 4'b1101);
        chk("zero_dz", Out_DivZero, 1);
        chk("zero_div_unchanged", bundle, {2'b01, 4'b1110, 4'b0101});
        drain();

        send(4'd1, 4'd3, 2'b00);
        send(4'd2, 4'd0, 2'b10);
        repeat (4) @(negedge Clock);
        chk("bp_full_ready", In_Ready, 0);
        chk("bp_full_valid", Out_Valid, 1);
        fork
            send(4'd9, 4'd6, 2'b11);
            begin
                repeat (3) begin
                    @(negedge Clock);
                    chk("bp_stall", In_Ready, 0);
                end
                @(posedge Clock);
                #1;
                Out_Ready = 1'b1;
                @(posedge Clock);
                #1;
                Out_Ready = 1'b0;
            end
        join
        repeat (5) @(negedge Clock);
        chk("bp_pending", exp_q.size(), 2);
        drain();
        chk("bp_drained", exp_q.size(), 0);

        @(posedge Clock);
        #1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            send(a, b, 2'($urandom_range(0, 3)));
        end
        repeat (5) @(negedge Clock);
        chk("stream_drained", exp_q.size(), 0);
        Out_Ready = 1'b0;

        send(4'd3, 4'd6, 2'b00);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_valid", Out_Valid, 0);
        chk("mid_rst_div", bundle, 0);
        exp_q.delete();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        chk("post_rst_no_stale", Out_Valid, 0);
        send(4'd5, 4'd3, 2'b10);
        measure({2'b10, 4'd5, 4'd3}, lat, busy);
        chk("post_rst_latency", lat, 2);
        drain();
        chk("post_rst_drained", exp_q.size(), 0);

        for (int m = 0; m < 4; m++) begin
            a = 4'($urandom_range(0, 15));
            send(a, 4'd7, 2'(m));
            measure({2'(m), a, 4'd7}, lat, busy);
            chk("mode_latency", lat, 2);
            chk("mode_drive_cycles", busy, 2);
            drain();
        end
        chk("mode_drained", exp_q.size(), 0);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    a = 4'($urandom_range(0, 15));
                    b = ($urandom_range(0, 3) == 0) ? 4'd0 :
                        4'($urandom_range(1, 15));
                    send(a, b, 2'($urandom_range(0, 3)));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge Clock);
                    #1;
                    Out_Ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge Clock);
        #1;
        Out_Ready = 1'b1;
        repeat (10) @(negedge Clock);
        chk("random_drained", exp_q.size(), 0);
        chk("final_valid", Out_Valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
